core_data_responder: RTL and testbench

Responder end of the cluster core data port (req/gnt/r_valid protocol carried by `core_data_req_t`/`core_data_rsp_t`). It accepts core data requests, serves them from a local flop-based word memory, and returns in-order responses after a configurable fixed latency. An external hold input can stall the block, for example when a scrubber or another arbiter is using the bank. It serves as a TCDM-bank or scratchpad model and as a reusable slave for peripheral test harnesses.

---
 rtl/core_data_responder_pkg.sv | 40 ++++
 rtl/core_data_rsp_pipe.sv | 45 ++++
 rtl/core_data_responder.sv | 112 +++++++++++
 tb/tb_core_data_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_data_responder_pkg.sv
// ============================================================================
// core_data_responder_pkg: shared cluster core-data port types and constants
// Rev 1.0
// ============================================================================
`default_nettype none

package core_data_responder_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic        req;
        logic [31:0] add;
        logic        we;
        word_t       data;
        logic [3:0]  be;
    } core_data_req_t;

    typedef struct packed {
        logic  gnt;
        word_t r_data;
        logic  r_valid;
    } core_data_rsp_t;

    localparam word_t       CoreDataErrRdata   = 32'hBADACCE5;
    localparam int unsigned CoreDataMaxLatency = 4;

    function automatic word_t be_merge(input word_t old_w, input word_t new_w,
                                       input logic [3:0] be);
        word_t res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_data_rsp_pipe.sv
// ============================================================================
// core_data_rsp_pipe: hold-able fixed-latency response delay line with busy flag
// Rev 1.0
// ============================================================================
`default_nettype none

module core_data_rsp_pipe #(
    parameter int unsigned Latency = 1,
    parameter int unsigned Width   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hold_i,
    input  logic             valid_i,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic             busy_o
);

    logic [Latency-1:0] valid_q;
    logic [Width-1:0]   data_q [Latency];

    // Grants only happen with hold low, so loading stage 0 under the shift is safe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < Latency; i++) data_q[i] <= '0;
        end else if (!hold_i) begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < Latency; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[Latency-1] & ~hold_i;
    assign data_o  = data_q[Latency-1];
    assign busy_o  = |valid_q;

endmodule

`default_nettype wire

// File: rtl/core_data_responder.sv
// ============================================================================
// core_data_responder: core data port responder over a flop word memory.
// Option macro CORE_DATA_RESPONDER_RANGE_CHECK_EN adds err_o range checking.
// Rev 1.0
// ============================================================================
`default_nettype none

module core_data_responder
    import core_data_responder_pkg::*;
#(
    parameter int unsigned NumWords = 256,
    parameter int unsigned Latency  = 1,
    parameter logic [31:0] BaseAddr = 32'h1000_0000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  core_data_req_t req_i,
    output core_data_rsp_t rsp_o,
    input  logic           hold_i,
    output logic [15:0]    rd_cnt_o,
    output logic [15:0]    wr_cnt_o,
    output logic           busy_o
`ifdef CORE_DATA_RESPONDER_RANGE_CHECK_EN
    ,
    output logic           err_o
`endif
);

    localparam int unsigned IdxW = $clog2(NumWords);

    logic            gnt;
    logic            hit;
    logic [IdxW-1:0] idx;
    word_t           rsp_data;
    word_t           mem_q [NumWords];
    logic [15:0]     rd_cnt_q, rd_cnt_d;
    logic [15:0]     wr_cnt_q, wr_cnt_d;
    logic            pipe_valid;

    assign gnt = req_i.req & ~hold_i;
    assign idx = IdxW'((req_i.add - BaseAddr) >> 2);

`ifdef CORE_DATA_RESPONDER_RANGE_CHECK_EN
    localparam int unsigned PayW = 33;
    logic [31:0] off;
    assign off = req_i.add - BaseAddr;
    assign hit = (req_i.add >= BaseAddr) && (off < 32'(NumWords * 4));
`else
    localparam int unsigned PayW = 32;
    assign hit = 1'b1;
`endif

    logic [PayW-1:0] pay_in, pay_out;

    always_comb begin
        rsp_data = req_i.we ? '0 : mem_q[idx];
        if (!hit) rsp_data = CoreDataErrRdata;
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (gnt && !req_i.we && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
        if (gnt &&  req_i.we && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            if (gnt && req_i.we && hit)
                mem_q[idx] <= be_merge(mem_q[idx], req_i.data, req_i.be);
        end
    end

`ifdef CORE_DATA_RESPONDER_RANGE_CHECK_EN
    assign pay_in = {~hit, rsp_data};
    assign err_o  = pay_out[32] & pipe_valid;
`else
    assign pay_in = rsp_data;
`endif

    core_data_rsp_pipe #(
        .Latency (Latency),
        .Width   (PayW)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .hold_i  (hold_i),
        .valid_i (gnt),
        .data_i  (pay_in),
        .valid_o (pipe_valid),
        .data_o  (pay_out),
        .busy_o  (busy_o)
    );

    always_comb begin
        rsp_o.gnt     = gnt;
        rsp_o.r_data  = pay_out[31:0];
        rsp_o.r_valid = pipe_valid;
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_core_data_responder.sv
// ============================================================================
// tb_core_data_responder: directed self-checking bench, Latency 1/2/3 instances
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_core_data_responder;
    import core_data_responder_pkg::*;

    localparam logic [31:0] B = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_data_req_t req1, req2, req3;
    core_data_rsp_t rsp1, rsp2, rsp3;
    logic           hold1, hold2, hold3;
    logic [15:0]    rd1, wr1, rd2, wr2, rd3, wr3;
    logic           busy1, busy2, busy3;
`ifdef CORE_DATA_RESPONDER_RANGE_CHECK_EN
    logic           err1, err2, err3;
`endif

    int checks   = 0;
    int failures = 0;

    core_data_responder #(.Latency(1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .rsp_o(rsp1), .hold_i(hold1),
        .rd_cnt_o(rd1), .wr_cnt_o(wr1), .busy_o(busy1)
`ifdef CORE_DATA_RESPONDER_RANGE_CHECK_EN
        , .err_o(err1)
`endif
    );

    core_data_responder #(.Latency(2)) u_l2 (
        .clk_i(clk), .rst_i(rst), .req_i(req2), .rsp_o(rsp2), .hold_i(hold2),
        .rd_cnt_o(rd2), .wr_cnt_o(wr2), .busy_o(busy2)
`ifdef CORE_DATA_RESPONDER_RANGE_CHECK_EN
        , .err_o(err2)
`endif
    );

    core_data_responder #(.Latency(3)) u_l3 (
        .clk_i(clk), .rst_i(rst), .req_i(req3), .rsp_o(rsp3), .hold_i(hold3),
        .rd_cnt_o(rd3), .wr_cnt_o(wr3), .busy_o(busy3)
`ifdef CORE_DATA_RESPONDER_RANGE_CHECK_EN
        , .err_o(err3)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        hold1 = 1'b0; hold2 = 1'b0; hold3 = 1'b0;
        req1  = '{1'b1, B, 1'b0, 32'h0, 4'h0};
        req2  = '0;
        req3  = '0;
        @(negedge clk);
        checks++;
        if (rsp1.gnt !== 1'b1) begin failures++; $display("FAIL reset_gnt got=%b exp=1", rsp1.gnt); end
        checks++;
        if (rsp1.r_valid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b exp=0", rsp1.r_valid); end
        checks++;
        if (rsp1.r_data !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rsp1.r_data); end
        checks++;
        if (rd1 !== 16'h0 || wr1 !== 16'h0) begin failures++; $display("FAIL reset_cnt got rd=%h wr=%h exp=0/0", rd1, wr1); end
        checks++;
        if (busy1 !== 1'b0 || busy3 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b/%b exp=0/0", busy1, busy3); end
        req1 = '0;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        req1 = '{1'b1, B + 32'd8, 1'b1, 32'hDEADBEEF, 4'hF};
        @(negedge clk);
        checks++;
        if (rsp1.gnt !== 1'b1 || rsp1.r_valid !== 1'b0) begin
            failures++; $display("FAIL wr_c0 got gnt=%b rv=%b exp gnt=1 rv=0", rsp1.gnt, rsp1.r_valid);
        end
        next_cycle();
        req1 = '{1'b1, B + 32'd8, 1'b0, 32'h0, 4'h0};
        @(negedge clk);
        checks++;
        if (rsp1.r_valid !== 1'b1 || rsp1.r_data !== 32'h0) begin
            failures++; $display("FAIL wr_rsp got rv=%b data=%h exp rv=1 data=0", rsp1.r_valid, rsp1.r_data);
        end
        next_cycle();
        req1 = '0;
        @(negedge clk);
        checks++;
        if (rsp1.r_valid !== 1'b1 || rsp1.r_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL rd_rsp got rv=%b data=%h exp rv=1 data=deadbeef", rsp1.r_valid, rsp1.r_data);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp1.r_valid !== 1'b0 || busy1 !== 1'b0 || rd1 !== 16'd1 || wr1 !== 16'd1) begin
            failures++; $display("FAIL wr_rd_idle got rv=%b busy=%b rd=%0d wr=%0d exp 0 0 1 1",
                                 rsp1.r_valid, busy1, rd1, wr1);
        end
        next_cycle();
    endtask

    task automatic test_byte_enable();
        req1 = '{1'b1, B + 32'd16, 1'b1, 32'h11223344, 4'hF};
        next_cycle();
        req1 = '{1'b1, B + 32'd16, 1'b1, 32'hAABBCCDD, 4'b0101};
        next_cycle();
        req1 = '{1'b1, B + 32'd16, 1'b1, 32'hFFFFFFFF, 4'b0000};
        next_cycle();
        req1 = '{1'b1, B + 32'd19, 1'b0, 32'h0, 4'h0};
        next_cycle();
        req1 = '0;
        @(negedge clk);
        checks++;
        if (rsp1.r_valid !== 1'b1 || rsp1.r_data !== 32'h11BB33DD) begin
            failures++; $display("FAIL byte_en got rv=%b data=%h exp rv=1 data=11bb33dd", rsp1.r_valid, rsp1.r_data);
        end
        next_cycle();
    endtask

    task automatic test_hold();
        word_t exp_d [3];
        logic  exp_g, exp_v;
        exp_d[0] = 32'hA0A0A0A0;
        exp_d[1] = 32'hB1B1B1B1;
        exp_d[2] = 32'hC2C2C2C2;
        for (int k = 0; k < 3; k++) begin
            req3 = '{1'b1, B + 32'(4 * k), 1'b1, exp_d[k], 4'hF};
            next_cycle();
        end
        req3 = '0;
        repeat (4) next_cycle();
        for (int c = 0; c < 9; c++) begin
            hold3 = (c == 3 || c == 4);
            if (c < 3)      req3 = '{1'b1, B + 32'(4 * c), 1'b0, 32'h0, 4'h0};
            else if (c < 5) req3 = '{1'b1, B, 1'b0, 32'h0, 4'h0};
            else            req3 = '0;
            exp_g = (c < 3);
            exp_v = (c >= 5 && c <= 7);
            @(negedge clk);
            checks++;
            if (rsp3.gnt !== exp_g || rsp3.r_valid !== exp_v) begin
                failures++; $display("FAIL hold_c%0d got gnt=%b rv=%b exp gnt=%b rv=%b",
                                     c, rsp3.gnt, rsp3.r_valid, exp_g, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (rsp3.r_data !== exp_d[c-5]) begin
                    failures++; $display("FAIL hold_data_c%0d got=%h exp=%h", c, rsp3.r_data, exp_d[c-5]);
                end
            end
            if (c == 3 || c == 8) begin
                checks++;
                if (busy3 !== (c == 3)) begin
                    failures++; $display("FAIL hold_busy_c%0d got=%b exp=%b", c, busy3, (c == 3));
                end
            end
            next_cycle();
        end
        hold3 = 1'b0;
    endtask

    task automatic test_reset_mid();
        req2 = '{1'b1, B + 32'd12, 1'b1, 32'h55AA55AA, 4'hF};
        next_cycle();
        req2 = '{1'b1, B + 32'd12, 1'b0, 32'h0, 4'h0};
        next_cycle();
        req2 = '0;
        rst  = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp2.r_valid !== 1'b0 || busy2 !== 1'b0 || rd2 !== 16'h0 || wr2 !== 16'h0) begin
            failures++; $display("FAIL rstmid got rv=%b busy=%b rd=%h wr=%h exp 0 0 0 0",
                                 rsp2.r_valid, busy2, rd2, wr2);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp2.r_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after got rv=%b exp=0", rsp2.r_valid); end
        next_cycle();
        req2 = '{1'b1, B + 32'd12, 1'b0, 32'h0, 4'h0};
        next_cycle();
        req2 = '0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (rsp2.r_valid !== 1'b1 || rsp2.r_data !== 32'h0) begin
            failures++; $display("FAIL rstmid_mem got rv=%b data=%h exp rv=1 data=0", rsp2.r_valid, rsp2.r_data);
        end
        next_cycle();
    endtask

    task automatic test_saturation();
        req1 = '{1'b1, B, 1'b0, 32'h0, 4'h0};
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if (rd1 !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", rd1); end
        repeat (6) @(posedge clk);
        #1;
        req1 = '0;
        checks++;
        if (rd1 !== 16'hFFFF || wr1 !== 16'h0) begin
            failures++; $display("FAIL sat got rd=%h wr=%h exp rd=ffff wr=0", rd1, wr1);
        end
        next_cycle();
    endtask

`ifdef CORE_DATA_RESPONDER_RANGE_CHECK_EN
    task automatic test_range();
        req1 = '{1'b1, B + 32'h400, 1'b0, 32'h0, 4'h0};
        next_cycle();
        req1 = '{1'b1, B - 32'd4, 1'b1, 32'h12345678, 4'hF};
        @(negedge clk);
        checks++;
        if (rsp1.r_valid !== 1'b1 || rsp1.r_data !== 32'hBADACCE5 || err1 !== 1'b1) begin
            failures++; $display("FAIL range_rd got rv=%b data=%h err=%b exp 1 badacce5 1",
                                 rsp1.r_valid, rsp1.r_data, err1);
        end
        next_cycle();
        req1 = '{1'b1, B + 32'h3FC, 1'b0, 32'h0, 4'h0};
        @(negedge clk);
        checks++;
        if (rsp1.r_data !== 32'hBADACCE5 || err1 !== 1'b1) begin
            failures++; $display("FAIL range_wr got data=%h err=%b exp badacce5 1", rsp1.r_data, err1);
        end
        next_cycle();
        req1 = '0;
        @(negedge clk);
        checks++;
        if (rsp1.r_valid !== 1'b1 || rsp1.r_data !== 32'h0 || err1 !== 1'b0) begin
            failures++; $display("FAIL range_alias got rv=%b data=%h err=%b exp 1 0 0",
                                 rsp1.r_valid, rsp1.r_data, err1);
        end
        next_cycle();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_hold();
        test_reset_mid();
        test_saturation();
`ifdef CORE_DATA_RESPONDER_RANGE_CHECK_EN
        test_range();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
